// File: rtl/wb_ps2_rx_fifo.sv
// Wishbone PS/2 receiver with a parametrised byte FIFO, parity/stop checking and sticky error flags.
// Optional idle-clock watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module wb_ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FIFO_AW        = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        intr,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] ADR_CTRL = 8'h00;
  localparam logic [7:0] ADR_DATA = 8'h10;

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] dat_sync_reg;
  logic                   clk_prev_reg;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  logic [1:0]         state_reg;
  logic [2:0]         bitcnt_reg;
  logic [7:0]         shift_reg;
  logic               parity_reg;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW:0]   wptr_reg;
  logic [FIFO_AW:0]   rptr_reg;
  logic [FIFO_AW:0]   count;
  logic               empty;
  logic               full;

  logic               irq_en_reg;
  logic               rx_en_reg;
  logic               ovf_reg;
  logic               perr_reg;
  logic               ferr_reg;
  logic               ack_reg;
  logic               intr_reg;
  logic [31:0]        dat_o_reg;

  logic               access;
  logic               ctrl_wr;
  logic               data_rd;
  logic               pop;
  logic               frame_done;
  logic               par_ok;
  logic               push_req;
  logic               do_push;
  logic               set_ovf;
  logic               set_perr;
  logic               set_ferr;
  logic               timeout_hit;
  logic [31:0]        stat_word;
  logic               unused_bits;

  // Idle-high reset value keeps a spurious falling edge from appearing after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_reg <= '1;
      dat_sync_reg <= '1;
      clk_prev_reg <= 1'b1;
    end else begin
      clk_sync_reg <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk_in};
      dat_sync_reg <= {dat_sync_reg[SYNC_STAGES-2:0], ps2_dat_in};
      clk_prev_reg <= clk_s;
    end
  end

  assign clk_s = clk_sync_reg[SYNC_STAGES-1];
  assign dat_s = dat_sync_reg[SYNC_STAGES-1];
  assign fall  = clk_prev_reg & ~clk_s;

`ifdef PS2_RX_TIMEOUT_EN
  logic [31:0] to_cnt_reg;

  assign timeout_hit = rx_en_reg && (state_reg != ST_IDLE) && !fall &&
                       (to_cnt_reg == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state_reg == ST_IDLE || fall || timeout_hit || !rx_en_reg)
      to_cnt_reg <= '0;
    else
      to_cnt_reg <= to_cnt_reg + 32'd1;
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || !rx_en_reg || timeout_hit) begin
      state_reg  <= ST_IDLE;
      bitcnt_reg <= '0;
    end else if (fall) begin
      case (state_reg)
        ST_IDLE: begin
          if (!dat_s) begin
            state_reg  <= ST_DATA;
            bitcnt_reg <= '0;
          end
        end
        ST_DATA: begin
          shift_reg  <= {dat_s, shift_reg[7:1]};
          bitcnt_reg <= bitcnt_reg + 3'd1;
          if (bitcnt_reg == 3'd7)
            state_reg <= ST_PARITY;
        end
        ST_PARITY: begin
          parity_reg <= dat_s;
          state_reg  <= ST_STOP;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign frame_done = rx_en_reg && fall && (state_reg == ST_STOP);
  assign par_ok     = ^{shift_reg, parity_reg};
  assign push_req   = frame_done & dat_s & par_ok;
  assign set_perr   = frame_done & dat_s & ~par_ok;
  assign set_ferr   = (frame_done & ~dat_s) | timeout_hit;

  assign count   = wptr_reg - rptr_reg;
  assign empty   = (count == '0);
  assign full    = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign do_push = push_req & ~full;
  assign set_ovf = push_req & full;

  assign access  = wb_stb_i & wb_cyc_i & ~ack_reg;
  assign ctrl_wr = access & wb_we_i & (wb_adr_i[7:0] == ADR_CTRL);
  assign data_rd = access & ~wb_we_i & (wb_adr_i[7:0] == ADR_DATA);
  assign pop     = data_rd & ~empty;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wptr_reg[FIFO_AW-1:0]] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
    end else begin
      if (do_push)
        wptr_reg <= wptr_reg + 1'b1;
      if (pop)
        rptr_reg <= rptr_reg + 1'b1;
    end
  end

  // A hardware set in the same cycle as a write-one-to-clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en_reg <= 1'b0;
      rx_en_reg  <= 1'b1;
      ovf_reg    <= 1'b0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en_reg <= wb_dat_i[0];
        rx_en_reg  <= wb_dat_i[1];
      end
      ovf_reg  <= set_ovf  | (ovf_reg  & ~(ctrl_wr & wb_dat_i[10]));
      perr_reg <= set_perr | (perr_reg & ~(ctrl_wr & wb_dat_i[11]));
      ferr_reg <= set_ferr | (ferr_reg & ~(ctrl_wr & wb_dat_i[12]));
    end
  end

  always_comb begin
    stat_word        = '0;
    stat_word[0]     = irq_en_reg;
    stat_word[1]     = rx_en_reg;
    stat_word[8]     = ~empty;
    stat_word[9]     = full;
    stat_word[10]    = ovf_reg;
    stat_word[11]    = perr_reg;
    stat_word[12]    = ferr_reg;
    stat_word[23:16] = 8'(count);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_reg   <= 1'b0;
      dat_o_reg <= '0;
      intr_reg  <= 1'b0;
    end else begin
      ack_reg  <= wb_stb_i & wb_cyc_i & ~ack_reg;
      intr_reg <= irq_en_reg & (~empty | ovf_reg | perr_reg | ferr_reg);
      if (access) begin
        if (wb_we_i)
          dat_o_reg <= '0;
        else if (wb_adr_i[7:0] == ADR_CTRL)
          dat_o_reg <= stat_word;
        else if (pop)
          dat_o_reg <= {23'b0, 1'b1, mem[rptr_reg[FIFO_AW-1:0]]};
        else
          dat_o_reg <= '0;
      end
    end
  end

  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack_reg;
  assign wb_dat_o = dat_o_reg;
  assign intr     = intr_reg;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i[31:13], wb_dat_i[9:2]};

endmodule

// File: tb/tb_wb_ps2_rx_fifo.sv
// Randomised bench for wb_ps2_rx_fifo: queue-based reference model plus directed literal checks.
// Define PS2_RX_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=100.
module tb_wb_ps2_rx_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        intr;
  logic        ps2_clk_in = 1'b1;
  logic        ps2_dat_in = 1'b1;

  wb_ps2_rx_fifo #(
    .FIFO_DEPTH(DEPTH), .FIFO_AW(4), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .intr(intr),
    .ps2_clk_in(ps2_clk_in), .ps2_dat_in(ps2_dat_in)
  );

  always #5 clk = ~clk;

  // Reference model: the FIFO is a plain queue, flags are plain bits.
  logic [7:0] q[$];
  logic m_irq_en, m_rx_en, m_ovf, m_perr, m_ferr;
  int   checks = 0;
  int   errors = 0;
  logic stable = 1'b0;

  function automatic logic [31:0] m_stat();
    logic [31:0] s;
    s        = '0;
    s[0]     = m_irq_en;
    s[1]     = m_rx_en;
    s[8]     = (q.size() != 0);
    s[9]     = (q.size() == DEPTH);
    s[10]    = m_ovf;
    s[11]    = m_perr;
    s[12]    = m_ferr;
    s[23:16] = 8'(q.size());
    return s;
  endfunction

  function automatic logic m_intr();
    return m_irq_en & ((q.size() != 0) | m_ovf | m_perr | m_ferr);
  endfunction

  task automatic model_reset();
    q.delete();
    m_irq_en = 1'b0; m_rx_en = 1'b1;
    m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else
      $display("ok   %s: %08h", name, act);
  endtask

  // Every stable cycle: intr equals the model's level and ack stays low with no strobe.
  always @(negedge clk) begin
    if (stable) begin
      checks++;
      if (intr !== m_intr() || wb_ack_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_cycle: intr=%b ack=%b expected intr=%b ack=0", intr, wb_ack_o, m_intr());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    tick(2);
    stable = 1'b1;
  endtask

  task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int waited;
    stable = 1'b0;
    tick(1);
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1; wb_we_i = we;
    wb_adr_i = {24'h0, adr}; wb_dat_i = wd;
    waited = 0;
    rd = 'x;
    while (waited < 6) begin
      tick(1);
      waited++;
      if (wb_ack_o === 1'b1) break;
    end
    checks++;
    if (wb_ack_o !== 1'b1 || waited != 1) begin
      errors++;
      $display("FAIL ack_latency: got %0d cycles (ack=%b) expected 1", waited, wb_ack_o);
    end
    rd = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic rd_stat(output logic [31:0] v);
    bus(1'b0, 8'h00, 32'h0, v);
    check32("stat_vs_model", v, m_stat());
    settle();
  endtask

  task automatic rd_data(output logic [31:0] v);
    logic [31:0] exp;
    bus(1'b0, 8'h10, 32'h0, v);
    exp = (q.size() != 0) ? {23'b0, 1'b1, q.pop_front()} : 32'h0;
    check32("data_vs_model", v, exp);
    settle();
  endtask

  task automatic wr_ctrl(input logic [31:0] wd);
    logic [31:0] v;
    bus(1'b1, 8'h00, wd, v);
    m_irq_en = wd[0];
    m_rx_en  = wd[1];
    if (wd[10]) m_ovf  = 1'b0;
    if (wd[11]) m_perr = 1'b0;
    if (wd[12]) m_ferr = 1'b0;
    settle();
  endtask

  // Bits are sent LSB first; the device changes data while the clock is high.
  task automatic send_bits(input logic [10:0] bits, input int n);
    stable = 1'b0;
    for (int i = 0; i < n; i++) begin
      ps2_dat_in = bits[i];
      tick(4);
      ps2_clk_in = 1'b0;
      tick(4);
      ps2_clk_in = 1'b1;
    end
    ps2_dat_in = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                              input logic bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bits(frame_bits(b, bad_par, bad_stop), 11);
    tick(6);
    if (m_rx_en) begin
      if (bad_stop)              m_ferr = 1'b1;
      else if (bad_par)          m_perr = 1'b1;
      else if (q.size() == DEPTH) m_ovf = 1'b1;
      else                       q.push_back(b);
    end
    settle();
  endtask

  task automatic do_reset();
    stable = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    model_reset();
    settle();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] wd;
    int op;
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(1);
    check32("reset_dat_o", wb_dat_o, 32'h0);
    check32("reset_intr", {31'b0, intr}, 32'h0);
    settle();
    rd_stat(v);
    check32("reset_stat", v, 32'h0000_0002);

    // Single frame 0x1C.
    send_frame(8'h1C, 1'b0, 1'b0);
    rd_stat(v);  check32("t1_stat", v, 32'h0001_0102);
    rd_data(v);  check32("t1_data", v, 32'h0000_011C);
    rd_stat(v);  check32("t1_stat_after", v, 32'h0000_0002);
    rd_data(v);  check32("t1_empty_read", v, 32'h0);

    // Interrupt follows not_empty while enabled.
    wr_ctrl(32'h3);
    send_frame(8'hF0, 1'b0, 1'b0);
    check32("t2_intr_high", {31'b0, intr}, 32'h1);
    rd_data(v);  check32("t2_data", v, 32'h0000_01F0);
    check32("t2_intr_low", {31'b0, intr}, 32'h0);
    wr_ctrl(32'h2);

    // Overflow: 17 frames into 16 entries.
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b0, 1'b0);
    rd_stat(v);  check32("t3_full_ovf", v, 32'h0010_0702);
    for (int i = 0; i < 16; i++) begin
      rd_data(v);
      check32("t3_drain", v, 32'h100 + 32'(i));
    end
    wr_ctrl(32'h402);
    rd_stat(v);  check32("t3_ovf_clear", v, 32'h0000_0002);

    // Parity and framing errors.
    send_frame(8'h1C, 1'b1, 1'b0);
    rd_stat(v);  check32("t4_parity", v, 32'h0000_0802);
    send_frame(8'h33, 1'b0, 1'b1);
    rd_stat(v);  check32("t4_frame", v, 32'h0000_1802);
    wr_ctrl(32'h1C02);

    // DATA read aligned with the push of a fourth byte.
    send_frame(8'hA1, 1'b0, 1'b0);
    send_frame(8'hA2, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b0, 1'b0);
    send_bits(frame_bits(8'hA4, 1'b0, 1'b0), 10);
    ps2_dat_in = 1'b1;
    tick(4);
    ps2_clk_in = 1'b0;
    tick(1);
    bus(1'b0, 8'h10, 32'h0, v);
    check32("t5_race_data", v, {23'b0, 1'b1, q.pop_front()});
    check32("t5_race_lit", v, 32'h0000_01A1);
    tick(2);
    ps2_clk_in = 1'b1;
    tick(6);
    q.push_back(8'hA4);
    settle();
    rd_stat(v);  check32("t5_count3", v, 32'h0003_0102);

    // Reset mid-frame, then a clean frame.
    send_bits(frame_bits(8'h77, 1'b0, 1'b0), 5);
    do_reset();
    rd_stat(v);  check32("t5_reset_stat", v, 32'h0000_0002);
    send_frame(8'h5A, 1'b0, 1'b0);
    rd_data(v);  check32("t5_after_reset", v, 32'h0000_015A);

`ifdef PS2_RX_TIMEOUT_EN
    send_bits(frame_bits(8'h3C, 1'b0, 1'b0), 5);
    tick(120);
    m_ferr = 1'b1;
    settle();
    rd_stat(v);  check32("t6_timeout", v, 32'h0000_1002);
    send_frame(8'h3C, 1'b0, 1'b0);
    rd_data(v);  check32("t6_after", v, 32'h0000_013C);
    wr_ctrl(32'h1002);
`endif

    // Randomised traffic against the model.
    for (int it = 0; it < 160; it++) begin
      op = $urandom_range(0, 10);
      if (op <= 4) begin
        send_frame(8'($urandom), ($urandom % 8) == 0, ($urandom % 10) == 0);
      end else if (op <= 6) begin
        rd_data(v);
      end else if (op == 7) begin
        rd_stat(v);
      end else if (op == 8) begin
        wd        = $urandom;
        wd[9:2]   = 8'($urandom);
        wd[1]     = ($urandom % 6) != 0;
        wr_ctrl(wd);
      end else if (op == 9) begin
        send_bits(frame_bits(8'($urandom), 1'b0, 1'b0), $urandom_range(1, 10));
        tick(2);
        wr_ctrl({31'b0, m_irq_en});
        wr_ctrl({30'b0, 1'b1, m_irq_en});
      end else begin
        wd = $urandom;
        bus(1'b1, ($urandom % 2) ? 8'h10 : 8'h24, wd, v);
        settle();
        bus(1'b0, 8'h24, 32'h0, v);
        check32("other_addr", v, 32'h0);
        settle();
      end
    end
    rd_stat(v);
    while (q.size() != 0) rd_data(v);
    rd_data(v);

    stable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ps2_rx_fifo.md
Name: wb_ps2_rx_fifo

Overview:
Wishbone slave PS/2 keyboard/mouse receiver with a parametrised receive FIFO, per-frame parity and stop-bit checking, sticky error flags and a maskable interrupt. It sits on the LM32 Wishbone bus beside the other wb_* peripherals. It is the successor to the single-register PS/2 port: bytes are buffered, so software no longer loses scan codes between polls.

Parameters:
FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..256
FIFO_AW, 4, log2(FIFO_DEPTH)
SYNC_STAGES, 2, synchroniser flops on ps2_clk_in/ps2_dat_in; minimum 2
TIMEOUT_CYCLES, 50000, idle-clock watchdog limit in clk cycles (Optional Feature only)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
wb_stb_i  in  1  Wishbone strobe
wb_cyc_i  in  1  Wishbone cycle
wb_ack_o  out  1  Wishbone acknowledge
wb_we_i  in  1  write enable
wb_adr_i  in  32  address; only [7:0] decoded
wb_sel_i  in  4  byte selects; ignored, all accesses are full-word
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data, registered
intr  out  1  level interrupt, registered
ps2_clk_in  in  1  PS/2 clock line, asynchronous
ps2_dat_in  in  1  PS/2 data line, asynchronous

Behaviour:
- Reset (sync, high): wb_dat_o=0, ack=0, intr=0. FIFO is emptied. All sticky flags are cleared. Receiver goes to IDLE. irq_en=0, rx_en=1.
- Wishbone handshake:
  - ack_r is set one cycle after a stb&cyc request when ack_r=0, and is cleared the following cycle.
  - wb_ack_o = stb & cyc & ack_r. Every access has one wait state.
  - The read/write side effect happens in the same cycle ack_r is set.
- Register map (wb_adr_i[7:0]):
  - 0x00 CTRL/STAT:
    - bit0 irq_en, rw
    - bit1 rx_en, rw
    - bit8 not_empty, ro
    - bit9 full, ro
    - bit10 overflow, W1C
    - bit11 parity_err, W1C
    - bit12 frame_err, W1C
    - [23:16] count, ro, zero-extended
    - other bits read 0
  - 0x10 DATA:
    - Read returns {23'b0, valid, byte}; bits [7:0] are the oldest entry.
    - If not empty: valid=1 and the entry is popped.
    - If empty: the read returns 0 and nothing changes.
    - Writes are ignored.
  - Other addresses: read 0, write ignored, still acked.
- Input synchroniser and edge detect:
  - Both PS/2 lines pass through SYNC_STAGES flops.
  - A falling edge is the synchronised clock sampling 1 and then 0.
  - Data is sampled only on a falling edge.
- Receiver FSM:
  - IDLE: on an edge with dat=0, go to DATA with bitcnt=0. An edge with dat=1 is ignored.
  - DATA: shift dat in LSB first. After the 8th bit, go to PARITY.
  - PARITY: latch dat. Odd parity: the XOR of the 8 data bits and the parity bit must be 1. Go to STOP.
  - STOP: on the next edge:
    - dat=1 and parity good: push the byte.
    - dat=1 and parity bad: set parity_err, no push.
    - dat=0: set frame_err, no push (frame_err takes precedence over parity_err).
    - Return to IDLE in all cases.
  - rx_en=0 forces IDLE and abandons any partial frame. The FIFO is untouched.
- FIFO:
  - Read/write pointers are FIFO_AW+1 bits; count = wptr - rptr.
  - Push and pop in the same cycle: both happen, count unchanged.
  - Push when full: the byte is dropped, overflow is set, contents are unchanged.
  - Pop when empty is impossible (the read returns 0, no change).
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Sticky flags: if a hardware set and a W1C write land in the same cycle, the set wins.
- intr is registered: intr <= irq_en & (not_empty | overflow | parity_err | frame_err). This gives a one-cycle latency from the flag or irq_en change.
- Latency: the pushed byte is visible in count/not_empty on the cycle after the STOP edge.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is not IDLE and is cleared on each falling edge.
  - On reaching TIMEOUT_CYCLES, the FSM returns to IDLE, frame_err is set and the partial byte is discarded.
- Undefined: no counter, the TIMEOUT_CYCLES parameter is unused, and a stalled frame waits indefinitely.

Test Plan:
1. Send frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → STAT count=1, not_empty=1; DATA read returns 0x0000011C; a following STAT read shows count=0.
2. Set irq_en=1, then send 0xF0 (parity 1) → intr rises one cycle after the push; DATA read 0x1F0; intr falls one cycle after the pop.
3. Send 17 valid frames 0x00..0x10 with FIFO_DEPTH=16 → full=1, overflow=1; 16 reads return 0x100..0x10F; byte 0x10 is lost; write 0x400 to STAT → overflow=0.
4. Send 0x1C with parity 1 → parity_err=1, count=0; send a frame with stop 0 → frame_err=1, no push.
5. Issue a DATA read on the exact cycle a push lands with count=3 → the read returns the oldest byte, count stays 3; pulse reset mid-frame → count=0, flags 0, the next clean frame is received correctly.
6. With PS2_RX_TIMEOUT_EN defined and TIMEOUT_CYCLES=100: stop the clock after 4 data bits → frame_err=1 after 100 cycles; a subsequent full frame is received correctly.
